adc_capture_ctrl: RTL and testbench
===================================

Name: adc_capture_ctrl

Overview:
Sequences a multi-channel ADC sample capture. On a start command it latches the parallel per-channel frame from the ADC datapath on each `adc_valid`. It then serializes the enabled channels, lowest index first, onto a single valid/ready stream. Capture ends after a programmed number of frames or on stop. The block sits between the ADC sampling datapath (or its simulation data generator) and the downstream FIFO/DMA.

Parameters:
- CHANNEL_NUM, 4, number of ADC channels in the parallel frame (1..16).
- ADC_BIT_NUM, 10, significant bits per channel sample.
- OUTPUT_BIT_NUM, 16, per-channel lane width on the input bus and width of the output sample (>= ADC_BIT_NUM).
- CNT_WIDTH, 16, width of the frame count and overrun counter.

Ports:
- clk, input, 1, single clock for everything.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, pulse; begins a capture when idle.
- stop, input, 1, pulse; ends a capture early.
- ch_en, input, CHANNEL_NUM, channel enable mask; sampled at start.
- frame_num, input, CNT_WIDTH, number of frames to capture; sampled at start.
- adc_data, input, OUTPUT_BIT_NUM*CHANNEL_NUM, channel i occupies bits [i*OUTPUT_BIT_NUM +: OUTPUT_BIT_NUM]; only the low ADC_BIT_NUM bits are used.
- adc_valid, input, 1, one-cycle frame strobe.
- m_data, output, OUTPUT_BIT_NUM, serialized sample.
- m_chan, output, 4, channel index of m_data.
- m_valid, output, 1, stream valid.
- m_ready, input, 1, stream ready.
- m_eof, output, 1, marks the last enabled channel of a frame.
- m_last, output, 1, marks the last beat of the capture.
- busy, output, 1, high from the accepted start until done.
- done, output, 1, one-cycle pulse at capture end.
- overrun_cnt, output, CNT_WIDTH, frames dropped during the current or last capture; saturates at all-ones.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, counters 0.
- IDLE:
  - An accepted start latches ch_en, frame_num and clears overrun_cnt.
  - If the latched mask or frame_num is zero, go to DONE. Otherwise go to WAIT and set busy = 1 the next cycle.
  - start is ignored in any other state.
- WAIT:
  - On adc_valid, latch adc_data into the frame register, load the pending mask = latched ch_en, and go to SEND.
  - The first m_valid is asserted the cycle after adc_valid (latency 1).
  - stop in WAIT goes directly to DONE.
- SEND:
  - m_data/m_chan present the lowest set bit of the pending mask.
  - On m_valid && m_ready, clear that bit.
  - When the last bit clears, increment the frame count. If the count equals frame_num or a stop is pending, go to DONE; else go to WAIT.
  - m_data, m_chan, m_eof and m_last must stay stable while m_valid && !m_ready.
  - m_eof = 1 when exactly one pending bit remains.
  - m_last = m_eof && (this is frame frame_num, or stop is pending).
- stop during SEND is registered as pending. The current frame completes fully; no truncated frames are emitted.
- adc_valid in SEND: the frame is dropped, overrun_cnt increments, and the frame count is not advanced. Simultaneous adc_valid with the final handshake of a frame is also an overrun; WAIT is entered the next cycle.
- DONE: busy = 0 and done = 1 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored.
- Width rule: output = zero-extended adc_data[ADC_BIT_NUM-1:0]; upper lane bits are discarded.
- Frame count is CNT_WIDTH wide and never wraps, since capture stops at frame_num.
- rst asserted mid-capture aborts immediately: m_valid drops the next edge, no done pulse.

Optional Feature:
- Macro: ADC_CAPTURE_SIGN_EXT_EN.
- When defined, samples are treated as two's complement and sign-extended from bit ADC_BIT_NUM-1 to OUTPUT_BIT_NUM.
- When undefined, samples are zero-extended.
- No other behaviour changes.

Decomposition:
- Shared package adc_capture_pkg:
  - State enum IDLE/WAIT/SEND/DONE.
  - Function lowest_set_index(mask) returning the index and a one-hot value.
  - Constant CHAN_IDX_W = 4.
- Sub-module adc_frame_serializer: frame register, pending mask, priority select, output hold logic. The FSM and counters stay in the top.

Test Plan:
- ch_en=4'b1111, frame_num=2, adc_valid every 8 cycles with channel i = 0x10+i, m_ready=1.
  - Expect 8 beats, channels 0,1,2,3,0,1,2,3.
  - Expect m_eof on beats 4 and 8, m_last on beat 8.
  - Expect a done pulse one cycle after beat 8 and overrun_cnt=0.
- ch_en=4'b1010, frame_num=1, m_ready toggling 1/0.
  - Expect beats ch1 then ch3, values held stable while stalled, m_last on ch3.
- frame_num=3, m_ready=0 for 20 cycles, adc_valid every 4 cycles.
  - Expect overrun_cnt=4 and dropped frames absent from the stream.
  - Expect the capture to still complete 3 full frames.
- stop asserted mid-frame 2 of frame_num=10.
  - Expect frame 2 to complete with m_last on its final beat, then done.
  - stop in WAIT gives done the next cycle with no beats.
- ch_en=0 or frame_num=0 on start: expect done 1 cycle after start, no m_valid, busy stays 0. Also rst mid-SEND: m_valid=0 next cycle, no done.
- ADC_BIT_NUM=10, sample 10'h3FF:
  - Without the macro, m_data=16'h03FF.
  - With ADC_CAPTURE_SIGN_EXT_EN, m_data=16'hFFFF.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC capture controller: FSM state encoding
// and the lowest-set-channel priority select used by the serializer.
package adc_capture_pkg;

  localparam int CHAN_IDX_W   = 4;
  localparam int MAX_CHANNELS = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND,
    DONE
  } state_t;

  typedef struct packed {
    logic [CHAN_IDX_W-1:0]   idx;
    logic [MAX_CHANNELS-1:0] onehot;
  } chan_sel_t;

  // Scans high to low so the lowest set bit is the last one written.
  function automatic chan_sel_t lowest_set_index(input logic [MAX_CHANNELS-1:0] mask);
    chan_sel_t sel;
    sel = '0;
    for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        sel.idx    = CHAN_IDX_W'(i);
        sel.onehot = MAX_CHANNELS'(1) << i;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/adc_frame_serializer.sv
// Holds one captured ADC frame and streams its enabled channels lowest-first.
// Define ADC_CAPTURE_SIGN_EXT_EN to sign-extend samples instead of zero-extending.
module adc_frame_serializer
  import adc_capture_pkg::*;
#(
  parameter int CHANNEL_NUM    = 4,
  parameter int ADC_BIT_NUM    = 10,
  parameter int OUTPUT_BIT_NUM = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load,
  input  logic [CHANNEL_NUM*OUTPUT_BIT_NUM-1:0] adc_data,
  input  logic [CHANNEL_NUM-1:0]                mask,
  input  logic                                  m_ready,
  output logic [OUTPUT_BIT_NUM-1:0]             m_data,
  output logic [CHAN_IDX_W-1:0]                 m_chan,
  output logic                                  m_valid,
  output logic                                  m_eof,
  output logic                                  frame_done
);

  function automatic logic [OUTPUT_BIT_NUM-1:0] extend(input logic [ADC_BIT_NUM-1:0] raw);
`ifdef ADC_CAPTURE_SIGN_EXT_EN
    logic signed [ADC_BIT_NUM-1:0]    raw_s;
    logic signed [OUTPUT_BIT_NUM-1:0] wide_s;
    raw_s  = signed'(raw);
    wide_s = OUTPUT_BIT_NUM'(raw_s);
    return unsigned'(wide_s);
`else
    return OUTPUT_BIT_NUM'(raw);
`endif
  endfunction

  logic [CHANNEL_NUM*ADC_BIT_NUM-1:0] frame_p0;
  logic [CHANNEL_NUM-1:0]             pending_p0;
  logic                               vld_p0;
  chan_sel_t                          sel;
  logic [CHANNEL_NUM-1:0]             sel_bit;
  logic                               fire;
  logic                               unused_bits;

  // Stage p0: frame register and pending mask; outputs depend only on these,
  // so they hold steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        frame_p0[i*ADC_BIT_NUM +: ADC_BIT_NUM] <= adc_data[i*OUTPUT_BIT_NUM +: ADC_BIT_NUM];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_p0 <= '0;
    end else if (load) begin
      pending_p0 <= mask;
    end else if (fire) begin
      pending_p0 <= pending_p0 & ~sel_bit;
    end
  end

  assign sel        = lowest_set_index(MAX_CHANNELS'(pending_p0));
  assign sel_bit    = sel.onehot[CHANNEL_NUM-1:0];
  assign vld_p0     = |pending_p0;
  assign fire       = vld_p0 && m_ready;
  assign m_valid    = vld_p0;
  assign m_eof      = vld_p0 && (pending_p0 == sel_bit);
  assign frame_done = fire && m_eof;
  assign m_chan     = sel.idx;
  assign m_data     = vld_p0 ? extend(frame_p0[int'(sel.idx)*ADC_BIT_NUM +: ADC_BIT_NUM]) : '0;

  // Upper lane bits are discarded by design.
  assign unused_bits = ^{adc_data, sel.onehot};

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: start/stop FSM, frame and overrun counters, driving the
// frame serializer. Define ADC_CAPTURE_SIGN_EXT_EN for two's-complement samples.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int CHANNEL_NUM    = 4,
  parameter int ADC_BIT_NUM    = 10,
  parameter int OUTPUT_BIT_NUM = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  stop,
  input  logic [CHANNEL_NUM-1:0]                ch_en,
  input  logic [CNT_WIDTH-1:0]                  frame_num,
  input  logic [CHANNEL_NUM*OUTPUT_BIT_NUM-1:0] adc_data,
  input  logic                                  adc_valid,
  output logic [OUTPUT_BIT_NUM-1:0]             m_data,
  output logic [CHAN_IDX_W-1:0]                 m_chan,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic                                  m_eof,
  output logic                                  m_last,
  output logic                                  busy,
  output logic                                  done,
  output logic [CNT_WIDTH-1:0]                  overrun_cnt
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t                 state;
  logic [CHANNEL_NUM-1:0] ch_en_q;
  logic [CNT_WIDTH-1:0]   frame_num_q;
  logic [CNT_WIDTH-1:0]   frame_cnt;
  logic                   stop_pend;
  logic                   load;
  logic                   frame_done;
  logic                   last_frame;

  assign load       = (state == WAIT) && adc_valid && !stop && !stop_pend;
  assign last_frame = (frame_cnt + CNT_WIDTH'(1)) == frame_num_q;
  assign m_last     = m_eof && (last_frame || stop_pend);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      ch_en_q     <= '0;
      frame_num_q <= '0;
      frame_cnt   <= '0;
      overrun_cnt <= '0;
      stop_pend   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ch_en_q     <= ch_en;
            frame_num_q <= frame_num;
            frame_cnt   <= '0;
            overrun_cnt <= '0;
            stop_pend   <= 1'b0;
            if (ch_en == '0 || frame_num == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WAIT;
              busy  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (stop || stop_pend) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (adc_valid) begin
            state <= SEND;
          end
        end
        SEND: begin
          // A frame arriving while one is still streaming is dropped and counted.
          if (adc_valid) overrun_cnt <= sat_inc(overrun_cnt);
          if (stop) stop_pend <= 1'b1;
          if (frame_done) begin
            frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            if (last_frame || stop_pend) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  adc_frame_serializer #(
    .CHANNEL_NUM    (CHANNEL_NUM),
    .ADC_BIT_NUM    (ADC_BIT_NUM),
    .OUTPUT_BIT_NUM (OUTPUT_BIT_NUM)
  ) u_serializer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .adc_data   (adc_data),
    .mask       (ch_en_q),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_chan     (m_chan),
    .m_valid    (m_valid),
    .m_eof      (m_eof),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Testbench for adc_capture_ctrl: table-driven capture scenarios, hand-written
// corner sequences and randomized captures checked against a queue-based model.
module tb_adc_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, adc_valid, m_ready;
  logic [3:0]  ch_en;
  logic [15:0] frame_num;
  logic [63:0] adc_data;
  logic [15:0] m_data;
  logic [3:0]  m_chan;
  logic        m_valid, m_eof, m_last, busy, done;
  logic [15:0] overrun_cnt;

  always #5 clk = ~clk;

  adc_capture_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .ch_en(ch_en),
    .frame_num(frame_num), .adc_data(adc_data), .adc_valid(adc_valid),
    .m_data(m_data), .m_chan(m_chan), .m_valid(m_valid), .m_ready(m_ready),
    .m_eof(m_eof), .m_last(m_last), .busy(busy), .done(done),
    .overrun_cnt(overrun_cnt)
  );

  typedef struct {
    logic [15:0] data;
    int          chan;
    bit          eof;
    int          frame;
  } beat_t;

  typedef struct {
    logic [3:0] ch_en;
    int         frame_num;
    int         period;      // 0 selects random stimulus
    int         ready_mode;  // 0 always, 1 toggle, 2 stalled first 20 cycles, 3 random
    int         stop_at;
    int         data_mode;   // 0 lanes 0x10+i, 1 lanes 0xA3FF, 2 random
    int         exp_beats;
    int         exp_overrun;
    int         exp_done_c;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: expected beats queued per accepted frame.
  beat_t      exp_q[$];
  bit         md_active, md_stop_pend, exp_busy, exp_done;
  logic [3:0] md_mask;
  int         md_fn, md_frames, md_overrun;
  logic [3:0] cur_ch_en;
  int         cur_fn;

  function automatic logic [15:0] ext_sample(input logic [15:0] lane);
`ifdef ADC_CAPTURE_SIGN_EXT_EN
    return lane[9] ? (16'hFC00 | (lane & 16'h03FF)) : (lane & 16'h03FF);
`else
    return lane & 16'h03FF;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    md_active = 0; md_stop_pend = 0; exp_busy = 0; exp_done = 0;
    md_mask = '0; md_fn = 0; md_frames = 0; md_overrun = 0;
  endtask

  task automatic step(input bit r, input bit st, input bit sp, input bit av, input bit rd,
                      input logic [63:0] data, output bit dut_fire);
    bit    nb, nd, old_sp;
    int    last_ch;
    beat_t b;
    @(negedge clk);
    rst = r; start = st; stop = sp; adc_valid = av; m_ready = rd; adc_data = data;
    ch_en = cur_ch_en; frame_num = 16'(cur_fn);
    chk("m_valid", 32'(m_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("m_data", 32'(m_data), 32'(exp_q[0].data));
      chk("m_chan", 32'(m_chan), exp_q[0].chan);
      chk("m_eof", 32'(m_eof), 32'(exp_q[0].eof));
      chk("m_last", 32'(m_last), 32'(exp_q[0].eof && (exp_q[0].frame == md_fn || md_stop_pend)));
    end
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("overrun_cnt", 32'(overrun_cnt), md_overrun);
    dut_fire = (m_valid === 1'b1) && rd;
    if (r) begin
      model_reset();
      return;
    end
    nb = exp_busy; nd = 0;
    if (exp_done) begin
      nb = 0;
    end else if (!md_active) begin
      if (st) begin
        md_mask = ch_en; md_fn = int'(frame_num); md_overrun = 0;
        md_frames = 0; md_stop_pend = 0;
        if (md_mask == 0 || md_fn == 0) nd = 1;
        else begin md_active = 1; nb = 1; end
      end
    end else if (exp_q.size() == 0) begin
      if (sp || md_stop_pend) begin
        md_active = 0; nb = 0; nd = 1;
      end else if (av) begin
        last_ch = -1;
        for (int i = 0; i < 4; i++) if (md_mask[i]) last_ch = i;
        for (int i = 0; i < 4; i++)
          if (md_mask[i])
            exp_q.push_back('{data: ext_sample(data[i*16 +: 16]), chan: i,
                               eof: (i == last_ch), frame: md_frames + 1});
      end
    end else begin
      old_sp = md_stop_pend;
      if (av && md_overrun < 65535) md_overrun++;
      if (sp) md_stop_pend = 1;
      if (rd) begin
        b = exp_q.pop_front();
        if (b.eof) begin
          md_frames++;
          if (md_frames == md_fn || old_sp) begin
            md_active = 0; nb = 0; nd = 1;
          end
        end
      end
    end
    exp_busy = nb; exp_done = nd;
  endtask

  task automatic run_vec(input vec_t v, output int beats, output int done_c,
                         output logic [15:0] first_data);
    beats = 0; done_c = -1; first_data = '0;
    cur_ch_en = v.ch_en; cur_fn = v.frame_num;
    for (int c = 0; c < 400; c++) begin
      bit st, sp, av, rd, f;
      logic [63:0] d;
      st = (c == 0);
      if (v.period == 0) begin
        av = ($urandom_range(0, 3) == 0);
        sp = ($urandom_range(0, 79) == 0);
      end else begin
        av = (c > 0) && (c % v.period == 0);
        sp = (v.stop_at > 0) && (c == v.stop_at);
      end
      case (v.ready_mode)
        0:       rd = 1;
        1:       rd = (c % 2 == 1);
        2:       rd = (c > 20);
        default: rd = ($urandom_range(0, 3) != 0);
      endcase
      case (v.data_mode)
        0:       d = 64'h0013_0012_0011_0010;
        1:       d = {4{16'hA3FF}};
        default: d = {$urandom(), $urandom()};
      endcase
      step(0, st, sp, av, rd, d, f);
      if (f) begin
        if (beats == 0) first_data = m_data;
        beats++;
      end
      if (done === 1'b1) begin
        done_c = c;
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[10];
    vec_t        rv;
    int          beats, done_c, seen;
    logic [15:0] fd;
    bit          f;

    vecs[0] = '{4'hF, 2,  8, 0, 0,  0, 8, 0, 21};
    vecs[1] = '{4'hA, 1,  8, 1, 0,  0, 2, 0, 12};
    vecs[2] = '{4'h7, 3,  4, 2, 0,  0, 9, 4, 32};
    vecs[3] = '{4'h0, 5,  8, 0, 0,  0, 0, 0, 1};
    vecs[4] = '{4'hF, 0,  8, 0, 0,  0, 0, 0, 1};
    vecs[5] = '{4'hF, 10, 8, 0, 18, 0, 8, 0, 21};
    vecs[6] = '{4'hF, 10, 8, 0, 3,  0, 0, 0, 4};
    vecs[7] = '{4'hF, 2,  2, 0, 0,  0, 8, 4, 13};
    vecs[8] = '{4'h1, 3,  3, 0, 0,  0, 3, 0, 11};
    vecs[9] = '{4'h1, 1,  8, 0, 0,  1, 1, 0, 10};

    rst = 1; start = 0; stop = 0; adc_valid = 0; m_ready = 0;
    ch_en = '0; frame_num = '0; adc_data = '0;
    cur_ch_en = '0; cur_fn = 0;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_chan", 32'(m_chan), 0);
    chk("rst_m_eof", 32'(m_eof), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overrun", 32'(overrun_cnt), 0);
    model_reset();
    step(0, 0, 0, 0, 1, '0, f);

    foreach (vecs[i]) begin
      run_vec(vecs[i], beats, done_c, fd);
      chk($sformatf("vec%0d_beats", i), beats, vecs[i].exp_beats);
      chk($sformatf("vec%0d_done_cycle", i), done_c, vecs[i].exp_done_c);
      chk($sformatf("vec%0d_overrun", i), 32'(overrun_cnt), vecs[i].exp_overrun);
      if (i == 9) begin
`ifdef ADC_CAPTURE_SIGN_EXT_EN
        chk("width_ext", 32'(fd), 32'h0000_FFFF);
`else
        chk("width_ext", 32'(fd), 32'h0000_03FF);
`endif
      end
    end

    // start during the DONE cycle must be ignored
    cur_ch_en = 4'h0; cur_fn = 3;
    step(0, 1, 0, 0, 1, '0, f);
    cur_ch_en = 4'hF; cur_fn = 1;
    step(0, 1, 0, 0, 1, '0, f);
    chk("done_before_ignored_start", 32'(done), 1);
    step(0, 0, 0, 1, 1, '0, f);
    chk("start_in_done_busy", 32'(busy), 0);
    step(0, 0, 0, 0, 1, '0, f);
    chk("start_in_done_idle", 32'(busy), 0);
    chk("start_in_done_no_beat", 32'(m_valid), 0);

    // rst in the middle of a stalled frame
    cur_ch_en = 4'hF; cur_fn = 2;
    step(0, 1, 0, 0, 0, '0, f);
    step(0, 0, 0, 0, 0, '0, f);
    step(0, 0, 0, 1, 0, 64'h0013_0012_0011_0010, f);
    step(0, 0, 0, 0, 0, '0, f);
    chk("pre_rst_m_valid", 32'(m_valid), 1);
    step(1, 0, 0, 0, 0, '0, f);
    step(0, 0, 0, 0, 1, '0, f);
    chk("rst_mid_m_valid", 32'(m_valid), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, (k % 2 == 0), 1, '0, f);
      if (done === 1'b1) seen++;
    end
    chk("rst_mid_no_done", seen, 0);

    // randomized captures against the model
    for (int n = 0; n < 25; n++) begin
      rv = '{4'($urandom_range(0, 15)), int'($urandom_range(0, 4)), 0, 3, 0, 2, 0, 0, 0};
      run_vec(rv, beats, done_c, fd);
      chk($sformatf("rand%0d_finished", n), 32'(done_c >= 0), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
